invntt_unload: RTL

//  Downstream drain stage of the inverse-NTT core. Once the invntt controller raises done,

---
 rtl/kyber_pkg.sv | 15 +
 rtl/mont_reduce.sv | 21 ++
 rtl/invntt_unload.sv | 119 +++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants and inverse-NTT unload state encoding
package kyber_pkg;

  localparam logic [11:0] KYBER_Q = 12'd3329;
  localparam logic [15:0] QINV    = 16'd62209;
  localparam logic [11:0] SCALE_F = 12'd1441;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } unload_state_e;

endpackage

// File: rtl/mont_reduce.sv
// rtl/mont_reduce.sv - combinational Montgomery reduce (p * 2^-16 mod q) into [0,q)
module mont_reduce
  import kyber_pkg::*;
(
  input  logic [23:0] p_i,
  output logic [11:0] r_o
);

  logic [15:0] m;
  logic [28:0] sum;
  logic [12:0] t;

  // QINV is q^-1 mod 2^16, so m = -p*QINV makes p + m*q divisible by 2^16; t lands in [0, q+91).
  always_comb begin
    m   = 16'd0 - (p_i[15:0] * QINV);
    sum = 29'(p_i) + 29'(m) * 29'(KYBER_Q);
    t   = 13'(sum >> 16);
    r_o = (t >= 13'(KYBER_Q)) ? 12'(t - 13'(KYBER_Q)) : t[11:0];
  end

endmodule

// File: rtl/invntt_unload.sv
// rtl/invntt_unload.sv - drains the result RAM, scales by F in Montgomery form, streams out
module invntt_unload
  import kyber_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int COEF_W = 16,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_i,
  input  logic              start_i,
  output logic [DEPTH-1:0]  rd_addr_o,
  input  logic [COEF_W-1:0] rd_data_i,
  output logic [COEF_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              full_out_o,
  output logic              busy_o
);

  localparam int CNTW = DEPTH + 1;
  localparam int PW   = $clog2(FIFO_D);
  localparam logic [CNTW-1:0] LAST = CNTW'((1 << DEPTH) - 1);

  unload_state_e   state_q, state_d;
  logic [CNTW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNTW-1:0] acc_cnt_q, acc_cnt_d;
  logic            dv_q, pv_q;
  logic [23:0]     p_q;
  logic [11:0]     r;
  logic [11:0]     fifo_q [FIFO_D];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     fifo_cnt_q;
  logic [PW+1:0]   credit;
  logic            issue, push, pop;
  logic            unused_rd_hi;

  assign unused_rd_hi = ^rd_data_i[COEF_W-1:12];

  mont_reduce u_mont_reduce (
    .p_i (p_q),
    .r_o (r)
  );

  // Credit counts FIFO entries plus reads still in the RAM/product stages, so the FIFO cannot overflow.
  assign credit      = (PW+2)'(fifo_cnt_q) + (PW+2)'(dv_q) + (PW+2)'(pv_q);
  assign issue       = (state_q == ST_RUN) && (credit < (PW+2)'(FIFO_D));
  assign push        = pv_q;
  assign out_valid_o = (fifo_cnt_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = out_valid_o ? {{(COEF_W-12){1'b0}}, fifo_q[rd_ptr_q]} : '0;
  assign rd_addr_o   = issue_cnt_q[DEPTH] ? {DEPTH{1'b1}} : issue_cnt_q[DEPTH-1:0];
  assign full_out_o  = (state_q == ST_DONE);
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // Next-state and counter logic; a started drain always runs to completion.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    if (issue) issue_cnt_d = issue_cnt_q + CNTW'(1);
    if (pop)   acc_cnt_d   = acc_cnt_q + CNTW'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          issue_cnt_d = '0;
          acc_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (issue && (issue_cnt_q == LAST)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && (acc_cnt_q == LAST)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!start_i) begin
          state_d     = ST_IDLE;
          issue_cnt_d = '0;
          acc_cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, pipeline and FIFO pointer registers, all stepped only when set_i is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      dv_q        <= 1'b0;
      pv_q        <= 1'b0;
      p_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else if (set_i) begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      dv_q        <= issue;
      pv_q        <= dv_q;
      if (dv_q) p_q <= 24'(rd_data_i[11:0]) * 24'(SCALE_F);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      fifo_cnt_q  <= fifo_cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // FIFO storage; stale entries are never visible because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (set_i && push) fifo_q[wr_ptr_q] <= r;
  end

endmodule
